sdram_pattern_tester: RTL
=========================

SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, SDRAM word-address width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 16, data width; legal range 8..32.
REQ-003 SHALL have parameter BURST_WIDTH, default 10, width of burst-length ports.
REQ-004 SHALL have parameter BURST_LEN, default 128, words per burst; 1..2^BURST_WIDTH-1.
REQ-005 SHALL have parameter BURST_NUM, default 16, bursts per pass; >=1.
REQ-006 SHALL have parameter BASE_ADDR, default 0, first word address of the test region.
REQ-007 SHALL have ports:
- i_sys_clk  in  1  sole clock.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start pulse.
- i_mode  in  2  pattern: 0 incr, 1 address, 2 LFSR, 3 walking-one.
- i_loop  in  1  repeat passes while high.
- o_busy  out  1  test running.
- o_done  out  1  one-cycle pulse at end of each pass.
- o_pass  out  1  last completed pass error-free.
- o_err_cnt  out  16  mismatches since start, saturating.
- o_pass_cnt  out  16  completed passes since start, wrapping.
- o_first_err_addr  out  ADDR_WIDTH  address of first mismatch.
- o_wr_burst_req/len/addr, i_wr_burst_data_req, o_wr_burst_data, i_wr_burst_finish: write-burst port, widths 1/BURST_WIDTH/ADDR_WIDTH/1/MEM_DATA_WIDTH/1.
- o_rd_burst_req/len/addr, i_rd_burst_data_valid, i_rd_burst_data, i_rd_burst_finish: read-burst port, same widths.

Function
REQ-008 SHALL use FSM IDLE -> WR_REQ -> WR_GAP -> (WR_REQ | RD_REQ) -> RD_GAP -> (RD_REQ | DONE) -> (WR_REQ if i_loop else IDLE).
REQ-009 SHALL, in IDLE on i_start, latch i_mode, clear o_err_cnt, o_pass_cnt, o_first_err_addr, burst index, word counters; enter WR_REQ; i_start ignored while o_busy.
REQ-010 SHALL hold o_*_burst_req high in *_REQ until matching *_finish; req, addr, len stable while req high.
REQ-011 SHALL drop req for exactly one cycle (*_GAP) between bursts; addr advances by BURST_LEN in the gap.
REQ-012 SHALL set burst addr = BASE_ADDR + k*BURST_LEN for burst k, len = BURST_LEN; last burst k = BURST_NUM-1.
REQ-013 SHALL update o_wr_burst_data on the edge where i_wr_burst_data_req is sampled high, to pattern(n), n = global word index 0..BURST_LEN*BURST_NUM-1.
REQ-014 SHALL define pattern(n): mode0 = n+1; mode1 = (BASE_ADDR+n) low bits; mode2 = low bits of 32-bit LFSR x^32+x^22+x^2+x+1, seed 0xFFFFFFFF, one step per word; mode3 = 1 << (n mod MEM_DATA_WIDTH); all truncated to MEM_DATA_WIDTH.
REQ-015 SHALL regenerate pattern(m) independently for reads, m advancing on each i_rd_burst_data_valid; mismatch increments o_err_cnt (saturate 0xFFFF).
REQ-016 SHALL capture o_first_err_addr = BASE_ADDR+m on the first mismatch only.
REQ-017 SHALL count a shortfall/excess of read-valid words vs BURST_LEN*BURST_NUM at DONE as one error.
REQ-018 SHALL in DONE pulse o_done, set o_pass = (pass error-free), increment o_pass_cnt; reseed generators for next pass.
REQ-019 SHALL drive o_busy high in all states except IDLE.
REQ-020 SHALL treat finish and data strobes outside the matching *_REQ state as don't-care, with no state change.

Reset
REQ-021 SHALL on i_sys_rst, any state, next edge: state IDLE; all req, o_busy, o_done, o_pass = 0; counters, addresses, lengths, data = 0; LFSRs = seed.
REQ-022 SHALL abandon any in-flight burst on reset without waiting for finish.

Configuration
REQ-023 SHALL with SDRAM_TEST_LFSR_EN defined implement mode 2 as in REQ-014.
REQ-024 SHALL without SDRAM_TEST_LFSR_EN omit the LFSR logic; mode 2 behaves identically to mode 0.

Verification
REQ-025 Mode0, BURST_LEN=8, BURST_NUM=2, ideal memory model, start -> 16 words 1..16 written at 0..15, o_done pulse, o_pass=1, o_err_cnt=0.
REQ-026 Mode1, model corrupts word at address 5 (bit0 flip) -> o_err_cnt=1, o_first_err_addr=5, o_pass=0.
REQ-027 Mode3, MEM_DATA_WIDTH=16, 20 words -> word 16 = 0x0001, word 15 = 0x8000; pass.
REQ-028 i_loop=1, 3 passes, model drops one read-valid in pass 2 -> o_pass_cnt=3, o_err_cnt=1, o_pass 1,0,1.
REQ-029 Reset asserted mid-write burst -> next cycle o_wr_burst_req=0, o_busy=0, state IDLE; new start runs clean pass.
REQ-030 Mode2 with and without SDRAM_TEST_LFSR_EN -> first written word 0xFFFF vs 0x0001.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// Burst-oriented SDRAM pattern tester: writes a pattern region, reads it back, counts mismatches.
// Define SDRAM_TEST_LFSR_EN to build the LFSR pattern (mode 2); otherwise mode 2 aliases mode 0.
module sdram_pattern_tester #(
   parameter int unsigned ADDR_WIDTH     = 24,
   parameter int unsigned MEM_DATA_WIDTH = 16,
   parameter int unsigned BURST_WIDTH    = 10,
   parameter int unsigned BURST_LEN      = 128,
   parameter int unsigned BURST_NUM      = 16,
   parameter int unsigned BASE_ADDR      = 0
) (
   input  logic                      i_sys_clk,
   input  logic                      i_sys_rst,
   input  logic                      i_start,
   input  logic [1:0]                i_mode,
   input  logic                      i_loop,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_pass,
   output logic [15:0]               o_err_cnt,
   output logic [15:0]               o_pass_cnt,
   output logic [ADDR_WIDTH-1:0]     o_first_err_addr,
   output logic                      o_wr_burst_req,
   output logic [BURST_WIDTH-1:0]    o_wr_burst_len,
   output logic [ADDR_WIDTH-1:0]     o_wr_burst_addr,
   input  logic                      i_wr_burst_data_req,
   output logic [MEM_DATA_WIDTH-1:0] o_wr_burst_data,
   input  logic                      i_wr_burst_finish,
   output logic                      o_rd_burst_req,
   output logic [BURST_WIDTH-1:0]    o_rd_burst_len,
   output logic [ADDR_WIDTH-1:0]     o_rd_burst_addr,
   input  logic                      i_rd_burst_data_valid,
   input  logic [MEM_DATA_WIDTH-1:0] i_rd_burst_data,
   input  logic                      i_rd_burst_finish
);

   localparam logic [31:0]               TotalWords = 32'(BURST_LEN * BURST_NUM);
   localparam logic [31:0]               LastBurst  = 32'(BURST_NUM - 1);
   localparam logic [31:0]               Base32     = 32'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0]     BaseAddr   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0]     AddrStep   = ADDR_WIDTH'(BURST_LEN);
   localparam logic [BURST_WIDTH-1:0]    BurstLen   = BURST_WIDTH'(BURST_LEN);
   localparam logic [MEM_DATA_WIDTH-1:0] WalkSeed   = MEM_DATA_WIDTH'(1);

   typedef enum logic [2:0] {
      StIdle, StWrReq, StWrGap, StRdReq, StRdGap, StDone
   } state_e;

   state_e                    state_q;
   logic [1:0]                mode_q;
   logic [31:0]               burst_q;
   logic [31:0]               wr_n_q;
   logic [31:0]               rd_m_q;
   logic [MEM_DATA_WIDTH-1:0] wr_walk_q;
   logic [MEM_DATA_WIDTH-1:0] rd_walk_q;
   logic                      pass_err_q;
   logic                      first_seen_q;
   logic [MEM_DATA_WIDTH-1:0] wr_pat;
   logic [MEM_DATA_WIDTH-1:0] rd_pat;

`ifdef SDRAM_TEST_LFSR_EN
   localparam logic [31:0] LfsrSeed = 32'hFFFF_FFFF;
   logic [31:0] wr_lfsr_q;
   logic [31:0] rd_lfsr_q;

   // x^32 + x^22 + x^2 + x + 1, shifting towards the MSB
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction
`endif

   function automatic logic [MEM_DATA_WIDTH-1:0] walk_step(input logic [MEM_DATA_WIDTH-1:0] w);
      return {w[MEM_DATA_WIDTH-2:0], w[MEM_DATA_WIDTH-1]};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Write and read sides each carry their own generator so reads never depend on write timing
   always_comb begin
      wr_pat = MEM_DATA_WIDTH'(wr_n_q + 32'd1);
      rd_pat = MEM_DATA_WIDTH'(rd_m_q + 32'd1);
      case (mode_q)
         2'd1: begin
            wr_pat = MEM_DATA_WIDTH'(Base32 + wr_n_q);
            rd_pat = MEM_DATA_WIDTH'(Base32 + rd_m_q);
         end
`ifdef SDRAM_TEST_LFSR_EN
         2'd2: begin
            wr_pat = wr_lfsr_q[MEM_DATA_WIDTH-1:0];
            rd_pat = rd_lfsr_q[MEM_DATA_WIDTH-1:0];
         end
`endif
         2'd3: begin
            wr_pat = wr_walk_q;
            rd_pat = rd_walk_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state_q          <= StIdle;
         mode_q           <= 2'd0;
         burst_q          <= '0;
         wr_n_q           <= '0;
         rd_m_q           <= '0;
         wr_walk_q        <= WalkSeed;
         rd_walk_q        <= WalkSeed;
         pass_err_q       <= 1'b0;
         first_seen_q     <= 1'b0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_pass           <= 1'b0;
         o_err_cnt        <= '0;
         o_pass_cnt       <= '0;
         o_first_err_addr <= '0;
         o_wr_burst_req   <= 1'b0;
         o_wr_burst_len   <= '0;
         o_wr_burst_addr  <= '0;
         o_wr_burst_data  <= '0;
         o_rd_burst_req   <= 1'b0;
         o_rd_burst_len   <= '0;
         o_rd_burst_addr  <= '0;
`ifdef SDRAM_TEST_LFSR_EN
         wr_lfsr_q        <= LfsrSeed;
         rd_lfsr_q        <= LfsrSeed;
`endif
      end else begin
         o_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (i_start) begin
                  mode_q           <= i_mode;
                  o_err_cnt        <= '0;
                  o_pass_cnt       <= '0;
                  o_first_err_addr <= '0;
                  first_seen_q     <= 1'b0;
                  pass_err_q       <= 1'b0;
                  burst_q          <= '0;
                  wr_n_q           <= '0;
                  rd_m_q           <= '0;
                  wr_walk_q        <= WalkSeed;
                  rd_walk_q        <= WalkSeed;
`ifdef SDRAM_TEST_LFSR_EN
                  wr_lfsr_q        <= LfsrSeed;
                  rd_lfsr_q        <= LfsrSeed;
`endif
                  o_wr_burst_addr  <= BaseAddr;
                  o_rd_burst_addr  <= BaseAddr;
                  o_wr_burst_len   <= BurstLen;
                  o_rd_burst_len   <= BurstLen;
                  o_wr_burst_req   <= 1'b1;
                  o_busy           <= 1'b1;
                  state_q          <= StWrReq;
               end
            end
            StWrReq: begin
               if (i_wr_burst_data_req) begin
                  o_wr_burst_data <= wr_pat;
                  wr_n_q          <= wr_n_q + 32'd1;
                  wr_walk_q       <= walk_step(wr_walk_q);
`ifdef SDRAM_TEST_LFSR_EN
                  wr_lfsr_q       <= lfsr_step(wr_lfsr_q);
`endif
               end
               if (i_wr_burst_finish) begin
                  o_wr_burst_req <= 1'b0;
                  state_q        <= StWrGap;
               end
            end
            StWrGap: begin
               if (burst_q == LastBurst) begin
                  burst_q         <= '0;
                  o_rd_burst_addr <= BaseAddr;
                  o_rd_burst_req  <= 1'b1;
                  state_q         <= StRdReq;
               end else begin
                  burst_q         <= burst_q + 32'd1;
                  o_wr_burst_addr <= o_wr_burst_addr + AddrStep;
                  o_wr_burst_req  <= 1'b1;
                  state_q         <= StWrReq;
               end
            end
            StRdReq: begin
               if (i_rd_burst_data_valid) begin
                  if (i_rd_burst_data != rd_pat) begin
                     o_err_cnt  <= sat_inc(o_err_cnt);
                     pass_err_q <= 1'b1;
                     if (!first_seen_q) begin
                        o_first_err_addr <= BaseAddr + ADDR_WIDTH'(rd_m_q);
                        first_seen_q     <= 1'b1;
                     end
                  end
                  rd_m_q    <= rd_m_q + 32'd1;
                  rd_walk_q <= walk_step(rd_walk_q);
`ifdef SDRAM_TEST_LFSR_EN
                  rd_lfsr_q <= lfsr_step(rd_lfsr_q);
`endif
               end
               if (i_rd_burst_finish) begin
                  o_rd_burst_req <= 1'b0;
                  state_q        <= StRdGap;
               end
            end
            StRdGap: begin
               if (burst_q == LastBurst) begin
                  state_q <= StDone;
               end else begin
                  burst_q         <= burst_q + 32'd1;
                  o_rd_burst_addr <= o_rd_burst_addr + AddrStep;
                  o_rd_burst_req  <= 1'b1;
                  state_q         <= StRdReq;
               end
            end
            StDone: begin
               // A wrong number of read words is one error, independent of data compares
               if (rd_m_q != TotalWords) o_err_cnt <= sat_inc(o_err_cnt);
               o_pass          <= !pass_err_q && (rd_m_q == TotalWords);
               o_done          <= 1'b1;
               o_pass_cnt      <= o_pass_cnt + 16'd1;
               pass_err_q      <= 1'b0;
               burst_q         <= '0;
               wr_n_q          <= '0;
               rd_m_q          <= '0;
               wr_walk_q       <= WalkSeed;
               rd_walk_q       <= WalkSeed;
`ifdef SDRAM_TEST_LFSR_EN
               wr_lfsr_q       <= LfsrSeed;
               rd_lfsr_q       <= LfsrSeed;
`endif
               o_wr_burst_addr <= BaseAddr;
               o_rd_burst_addr <= BaseAddr;
               if (i_loop) begin
                  o_wr_burst_req <= 1'b1;
                  state_q        <= StWrReq;
               end else begin
                  o_busy  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
